// File: rtl/boot_seq_pkg.sv
// Shared types and helpers for the board-level boot sequencer.
package boot_seq_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STRETCH   = 3'd2,
        PERIPH    = 3'd3,
        CORE      = 3'd4,
        RUN       = 3'd5
    } boot_state_e;

    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_PLL  = 1;
    localparam int CAUSE_KEY  = 2;
    localparam int CAUSE_JTAG = 3;
    localparam int CAUSE_SW   = 4;

    // Counter width able to hold 0..max_val-1; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser followed by a stability counter for the KEY pushbutton.
module key_debouncer
    import boot_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic key_stable_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]       key_sync;
    logic [CNT_W-1:0] cnt;

    // Synchroniser flops are free-running so they settle while reset is held.
    always_ff @(posedge clk) begin
        key_sync <= {key_sync[0], key_n_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            key_stable_o <= 1'b1;
        end else if (key_sync[1] == key_stable_o) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt          <= '0;
            key_stable_o <= key_sync[1];
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// Combines PLL, KEY, JTAG and software resets and releases peripheral reset,
// core reset and fetch enable in a fixed, timed order.
module boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES    = 250000,
    parameter int          RST_HOLD_CYCLES    = 16,
    parameter int          CORE_DELAY_CYCLES  = 8,
    parameter int          FETCH_DELAY_CYCLES = 4,
    parameter logic [31:0] BOOT_ADDR          = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_n_i,
    input  logic        jtag_reset_i,
    input  logic        pll_locked_i,
    input  logic        sw_reset_req_i,
    input  logic        cause_clr_i,
    output logic        periph_reset_n_o,
    output logic        core_reset_n_o,
    output logic        fetch_enable_o,
    output logic [31:0] boot_addr_o,
    output logic [2:0]  state_o,
    output logic [4:0]  reset_cause_o
);

    localparam int MAX_DLY_A = (RST_HOLD_CYCLES > CORE_DELAY_CYCLES) ? RST_HOLD_CYCLES : CORE_DELAY_CYCLES;
    localparam int MAX_DLY   = (MAX_DLY_A > FETCH_DELAY_CYCLES) ? MAX_DLY_A : FETCH_DELAY_CYCLES;
    localparam int CNT_W     = cnt_width(MAX_DLY);

    if (RST_HOLD_CYCLES < 1 || CORE_DELAY_CYCLES < 1 || FETCH_DELAY_CYCLES < 1 ||
        DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("boot_sequencer: every delay parameter must be at least 1");
    end

    boot_state_e      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       pll_sync;
    logic             locked_sync;
    logic             key_stable;
    logic             key_req, req, pll_abort;
    logic [4:0]       cause_set;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debouncer (
        .clk          (clk),
        .reset        (reset),
        .key_n_i      (key_n_i),
        .key_stable_o (key_stable)
    );

    always_ff @(posedge clk) begin
        pll_sync <= {pll_sync[0], pll_locked_i};
    end

    assign locked_sync = pll_sync[1];
    assign key_req     = ~key_stable;
    assign req         = key_req | jtag_reset_i | sw_reset_req_i;
    assign pll_abort   = ~locked_sync && (state inside {STRETCH, PERIPH, CORE, RUN});
    assign boot_addr_o = BOOT_ADDR;
    assign state_o     = state;

    always_comb begin
        cause_set             = '0;
        cause_set[CAUSE_PLL]  = pll_abort;
        cause_set[CAUSE_KEY]  = key_req;
        cause_set[CAUSE_JTAG] = jtag_reset_i;
        cause_set[CAUSE_SW]   = sw_reset_req_i;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (req || pll_abort) begin
            state_nx = HOLD;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                HOLD: state_nx = WAIT_LOCK;
                WAIT_LOCK: if (locked_sync) begin
                    state_nx = STRETCH;
                    cnt_nx   = '0;
                end
                STRETCH: if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                    state_nx = PERIPH;
                    cnt_nx   = '0;
                end else cnt_nx = cnt + 1'b1;
                PERIPH: if (cnt == CNT_W'(CORE_DELAY_CYCLES - 1)) begin
                    state_nx = CORE;
                    cnt_nx   = '0;
                end else cnt_nx = cnt + 1'b1;
                CORE: if (cnt == CNT_W'(FETCH_DELAY_CYCLES - 1)) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else cnt_nx = cnt + 1'b1;
                RUN:     state_nx = RUN;
                default: state_nx = HOLD;
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as state_o.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= HOLD;
            cnt              <= '0;
            periph_reset_n_o <= 1'b0;
            core_reset_n_o   <= 1'b0;
            fetch_enable_o   <= 1'b0;
            reset_cause_o    <= 5'b00001;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            periph_reset_n_o <= state_nx inside {PERIPH, CORE, RUN};
            core_reset_n_o   <= state_nx inside {CORE, RUN};
            fetch_enable_o   <= (state_nx == RUN);
            reset_cause_o    <= (cause_clr_i ? 5'b00000 : reset_cause_o) | cause_set;
        end
    end

endmodule
